// File: rtl/rand_pool_reader.sv
// rand_pool_reader: fires the generator's rise trigger, range-checks each settled sample and
// keeps accepted values in a show-ahead pool. Optional `RANDPOOL_NODUP_EN rejects repeats.
module rand_pool_reader #(
   parameter int                   SIZE_BITS = 8,
   parameter int                   DEPTH     = 4,
   parameter int                   SETTLE    = 2,
   parameter logic [SIZE_BITS-1:0] MIN_VAL   = '0,
   parameter logic [SIZE_BITS-1:0] MAX_VAL   = '1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SIZE_BITS-1:0]    rnd_in,
   output logic                    rise_out,
   input  logic                    pop,
   output logic [SIZE_BITS-1:0]    dout,
   output logic                    valid,
   output logic [$clog2(DEPTH):0]  count,
   output logic [7:0]              rejects
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(SETTLE + 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
   localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_SAMPLE} state_t;

   state_t                 state, state_nxt;
   logic [WW-1:0]          wait_cnt;
   logic                   settle_done, in_sample, rise_nxt;
   logic                   ge_min, le_max, accept, push, pop_ok, full;
   logic [SIZE_BITS-1:0]   mem [DEPTH];
   logic [AW-1:0]          rd_ptr, wr_ptr;

   assign full        = (count == FULL_CNT);
   assign valid       = (count != '0);
   assign pop_ok      = pop && valid;
   assign settle_done = (wait_cnt == WAIT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         rise_out <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rise_out <= rise_nxt;
         wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      end
   end

   // NOTE: every combinational output is defaulted first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!full) state_nxt = S_PULSE;
         S_PULSE:  state_nxt = S_WAIT;
         S_WAIT:   if (settle_done) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // rise_out is registered from the next state so it is high exactly during PULSE.
   always_comb begin
      in_sample = (state == S_SAMPLE);
      rise_nxt  = (state_nxt == S_PULSE);
   end

   // Open range bounds are tied off so no always-true comparison is built.
   if (MIN_VAL == '0) begin : g_min_open
      assign ge_min = 1'b1;
   end else begin : g_min_cmp
      assign ge_min = (rnd_in >= MIN_VAL);
   end

   if (MAX_VAL == {SIZE_BITS{1'b1}}) begin : g_max_open
      assign le_max = 1'b1;
   end else begin : g_max_cmp
      assign le_max = (rnd_in <= MAX_VAL);
   end

`ifdef RANDPOOL_NODUP_EN
   logic [SIZE_BITS-1:0] last_val;
   logic                 last_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_val <= '0;
         last_ok  <= 1'b0;
      end else if (push) begin
         last_val <= rnd_in;
         last_ok  <= 1'b1;
      end
   end

   assign accept = ge_min && le_max && !(last_ok && (rnd_in == last_val));
`else
   assign accept = ge_min && le_max;
`endif

   assign push = in_sample && accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rejects <= '0;
      end else if (in_sample && !accept && (rejects != 8'hFF)) begin
         rejects <= rejects + 1'b1;
      end
   end

   // NOTE: pool storage is not reset; pointers, count and the head register define its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rnd_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head register: next entry on pop, incoming value when it becomes the head, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= '0;
      end else if (pop_ok && (|count[AW:1])) begin
         dout <= mem[rd_ptr + 1'b1];
      end else if (push && (!valid || pop_ok)) begin
         dout <= rnd_in;
      end
   end

endmodule

// File: tb/tb_rand_pool_reader.sv
// tb_rand_pool_reader: queue-based pool model checked every cycle on the default instance,
// plus directed literal checks on a default and a narrowed-range instance.
module tb_rand_pool_reader;

   localparam int DEPTH     = 4;
   localparam int SETTLE    = 2;
   localparam int SAMPLE_PH = SETTLE + 2;

   logic       clk = 1'b0;
   logic       reset, reset_r;
   logic [7:0] rnd, rnd_r;
   logic       pop, pop_r;
   logic       rise_out, valid, rise_r, valid_r;
   logic [7:0] dout, rejects, dout_r, rej_r;
   logic [2:0] count, cnt_r;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rand_pool_reader #(.SIZE_BITS(8), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .reset(reset), .rnd_in(rnd), .rise_out(rise_out), .pop(pop),
      .dout(dout), .valid(valid), .count(count), .rejects(rejects));

   rand_pool_reader #(.SIZE_BITS(8), .DEPTH(DEPTH), .SETTLE(SETTLE),
                      .MIN_VAL(8'd10), .MAX_VAL(8'd20)) dut_r (
      .clk(clk), .reset(reset_r), .rnd_in(rnd_r), .rise_out(rise_r), .pop(pop_r),
      .dout(dout_r), .valid(valid_r), .count(cnt_r), .rejects(rej_r));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic restart();
      @(negedge clk);
      #2 reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   // Model: pool as a queue, attempt progress as a phase number within one attempt.
   logic [7:0] mq[$];
   int         ph, m_rej, sz;
   bit         m_rise, m_en, m_has_last, smp, acc, pok;
   logic [7:0] m_dout, m_last;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         ph = 0; m_rej = 0; m_rise = 1'b0; m_dout = 8'h00; m_last = 8'h00; m_has_last = 1'b0;
      end else begin
         sz  = mq.size();
         pok = pop && (sz != 0);
         smp = (ph == SAMPLE_PH);
         acc = 1'b1;
`ifdef RANDPOOL_NODUP_EN
         if (m_has_last && rnd == m_last) acc = 1'b0;
`endif
         if (pok) void'(mq.pop_front());
         if (smp) begin
            if (acc) begin
               mq.push_back(rnd);
               m_last = rnd;
               m_has_last = 1'b1;
            end else if (m_rej < 255) begin
               m_rej++;
            end
         end
         if (ph == 0)  ph = (sz < DEPTH) ? 1 : 0;
         else if (smp) ph = 0;
         else          ph++;
         m_rise = (ph == 1);
         if (mq.size() != 0) m_dout = mq[0];
      end
   end

   always @(negedge clk) begin
      if (m_en && !reset) begin
         check("model_rise",    32'(rise_out), 32'(m_rise));
         check("model_count",   32'(count),    mq.size());
         check("model_valid",   32'(valid),    32'(mq.size() != 0));
         check("model_dout",    32'(dout),     32'(m_dout));
         check("model_rejects", 32'(rejects),  m_rej);
      end
   end

   logic [7:0] vals_r [7] = '{8'd5, 8'd25, 8'd15, 8'd9, 8'd10, 8'd21, 8'd20};
   int         rej_tab[7] = '{1, 2, 2, 3, 3, 4, 4};
   int         cnt_tab[7] = '{0, 0, 1, 1, 2, 2, 3};
   bit         hi;

   initial begin
      reset = 1'b1; reset_r = 1'b1; rnd = 8'h37; rnd_r = 8'd5; pop = 1'b0; pop_r = 1'b0;
      m_en = 1'b0;
      step(3);
      reset = 1'b0;
      m_en  = 1'b1;

      // Constant 0x37: first trigger, first valid, fill timing.
      check("rst_rise",  32'(rise_out), 0);
      check("rst_valid", 32'(valid),    0);
      check("rst_count", 32'(count),    0);
      check("rst_dout",  32'(dout),     0);
      check("rst_rej",   32'(rejects),  0);
      step(1); check("c1_rise",     32'(rise_out), 1);
      step(1); check("c2_rise_low", 32'(rise_out), 0);
      step(2); check("c4_valid",    32'(valid),    0);
      step(1);
      check("c5_valid", 32'(valid), 1);
      check("c5_dout",  32'(dout),  'h37);
      check("c5_count", 32'(count), 1);
`ifndef RANDPOOL_NODUP_EN
      step(14); check("c19_count", 32'(count), 3);
      step(1);  check("c20_count", 32'(count), 4);
      hi = 1'b0;
      repeat (10) begin
         step(1);
         hi |= rise_out;
      end
      check("full_rise_quiet", 32'(hi), 0);
`else
      step(15); check("c20_count_nodup", 32'(count), 1);
`endif

      // Fill with 1..4, pop four times, then keep popping while empty.
      restart();
      for (int i = 0; i < 4; i++) begin
         rnd = 8'(i + 1);
         step(5);
      end
      check("full_count", 32'(count), 4);
      check("full_dout",  32'(dout),  1);
      rnd = 8'h5A;
      pop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("pop_dout",  32'(dout),  i + 2);
         check("pop_count", 32'(count), 3 - i);
         if (i == 1) check("refill_rise", 32'(rise_out), 1);
      end
      step(1);
      check("empty_valid", 32'(valid), 0);
      check("empty_count", 32'(count), 0);
      check("empty_dout",  32'(dout),  4);
      step(1);
      check("underflow_count", 32'(count), 0);
      check("underflow_dout",  32'(dout),  4);
      step(1);
      pop = 1'b0;
      check("refill_count", 32'(count), 1);
      check("refill_dout",  32'(dout),  'h5A);

      // Reset asserted during WAIT of the next attempt, then restart timing.
      step(2);
      check("pre_rst_count", 32'(count), 1);
      #2 reset = 1'b1;
      #1;
      check("midrst_rise",  32'(rise_out), 0);
      check("midrst_valid", 32'(valid),    0);
      check("midrst_count", 32'(count),    0);
      check("midrst_dout",  32'(dout),     0);
      check("midrst_rej",   32'(rejects),  0);
      rnd = 8'h37;
      step(1);
      reset = 1'b0;
      step(1); check("re_c1_rise",  32'(rise_out), 1);
      step(3); check("re_c4_valid", 32'(valid),    0);
      step(1);
      check("re_c5_valid", 32'(valid), 1);
      check("re_c5_dout",  32'(dout),  'h37);

`ifdef RANDPOOL_NODUP_EN
      // Constant 0x42: one accept, every later sample is a duplicate.
      rnd = 8'h42;
      restart();
      step(5);    check("dup_c5_count",  32'(count),   1);
      step(5);    check("dup_c10_rej",   32'(rejects), 1);
      step(1265); check("dup_rej_254",   32'(rejects), 254);
      step(5);    check("dup_rej_255",   32'(rejects), 255);
      step(100);
      check("dup_rej_hold", 32'(rejects), 255);
      check("dup_count",    32'(count),   1);
      check("dup_dout",     32'(dout),    'h42);
`endif

      // Range 10..20: outside values rejected, inclusive bounds accepted, saturation.
      @(negedge clk);
      reset_r = 1'b0;
      check("r_rst_rej", 32'(rej_r), 0);
      for (int i = 0; i < 7; i++) begin
         rnd_r = vals_r[i];
         step(5);
         check("r_rejects", 32'(rej_r), rej_tab[i]);
         check("r_count",   32'(cnt_r), cnt_tab[i]);
      end
      check("r_head",  32'(dout_r),  15);
      check("r_valid", 32'(valid_r), 1);
      rnd_r = 8'd5;
      step(1250); check("r_rej_254",  32'(rej_r), 254);
      step(5);    check("r_rej_255",  32'(rej_r), 255);
      step(100);
      check("r_rej_hold",  32'(rej_r),  255);
      check("r_count_end", 32'(cnt_r),  3);
      check("r_dout_end",  32'(dout_r), 15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rand_pool_reader.md
# rand_pool_reader

- Reader end of the key/counter random generator.
- Fires the generator's `rise` trigger itself, waits for the latched value to settle, then range-checks it.
- Accepted values are buffered in a small show-ahead FIFO.
- Game logic (e.g. gold/rock placement) pops pre-drawn random numbers with zero wait.

## Interface

Parameters:
- `SIZE_BITS`, 8: width of random values.
- `DEPTH`, 4: pool FIFO entries; power of two, 2..16.
- `SETTLE`, 2: wait cycles between trigger pulse and sample; must be ≥1.
- `MIN_VAL`, 0: smallest acceptable value, unsigned, inclusive.
- `MAX_VAL`, all ones: largest acceptable value, unsigned, inclusive; must be ≥ `MIN_VAL`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rnd_in`  in  SIZE_BITS  random value from the generator's `dout`.
- `rise_out`  out  1  trigger to the generator's `rise` input; registered.
- `pop`  in  1  consumer takes the head entry this cycle.
- `dout`  out  SIZE_BITS  FIFO head value; valid only when `valid` is high.
- `valid`  out  1  FIFO not empty.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `rejects`  out  8  saturating count of discarded samples.

## Operation

- FSM states: IDLE, PULSE, WAIT, SAMPLE.
- IDLE:
  - If `count` < DEPTH, go to PULSE next cycle.
  - Otherwise stay in IDLE.
- PULSE:
  - `rise_out`=1 for exactly this one cycle.
  - Always go to WAIT.
- WAIT:
  - `rise_out`=0.
  - Internal counter runs SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - Capture `rnd_in` and compare it unsigned against the range.
  - If `MIN_VAL` ≤ `rnd_in` ≤ `MAX_VAL`, push it.
  - Otherwise discard it and increment `rejects`; `rejects` holds at 255.
  - Always go to IDLE.
- `rise_out` is low for at least SETTLE+2 cycles between pulses, so every pulse is a clean rising edge for the generator.
- FIFO:
  - Show-ahead: `dout` shows the oldest entry; `valid` = (`count` != 0).
  - `pop` with `valid`=0 is ignored and has no side effect.
  - `pop` and push in the same cycle: `count` unchanged, head advances, new value is written at the tail.
  - A push can never happen when full: the fill check is made in IDLE, and `count` only grows by this block's own pushes.
- `dout` holds its value while the FIFO is empty; it does not change until the next push or pop.
- Reset (asynchronous, also mid-attempt):
  - State returns to IDLE and FIFO is emptied.
  - `rise_out`=0, `dout`=0, `valid`=0, `count`=0, `rejects`=0.
  - A trigger pulse interrupted by reset is abandoned, never sampled.

## Timing

- One attempt takes SETTLE+3 cycles: IDLE 1, PULSE 1, WAIT SETTLE, SAMPLE 1.
- After reset deasserts (cycle 0 in IDLE):
  - `rise_out` is high in cycle 1.
  - SAMPLE happens in cycle SETTLE+2.
  - `valid`/`count`/`dout` update at the end of SAMPLE, so they are visible from cycle SETTLE+3.
  - With SETTLE=2: first `valid` in cycle 5.
- Pop latency: `dout`/`count` update in the cycle after `pop` is sampled.
- With no pops and no rejects, FIFO is full after DEPTH·(SETTLE+3) cycles; after that `rise_out` stays 0.
- Generator contract: it latches on the first cycle it sees `rise` high after low, so its `dout` is stable from cycle PULSE+1. SETTLE≥1 covers this.

## Configuration

- Macro `RANDPOOL_NODUP_EN`.
- Defined:
  - SAMPLE also discards a value equal to the most recently pushed value and counts it in `rejects`.
  - The last-pushed register clears on reset; the first sample after reset is never a duplicate.
- Undefined:
  - No duplicate check; consecutive equal values are accepted.
  - No last-pushed register exists.

## Test plan

1. Reset, then drive `rnd_in`=0x37 constant (defaults) -> `rise_out` high in cycle 1, `valid` in cycle 5, `dout`=0x37; `count` reaches 4 by cycle 20, after which `rise_out` stays 0.
2. MIN_VAL=10, MAX_VAL=20, `rnd_in` sequence 5, 25, 15 on successive samples -> two rejects, `rejects`=2, first entry 15.
3. Full FIFO holding 1,2,3,4; `pop` for 4 consecutive cycles -> `dout` 1,2,3,4, `valid` falls after the 4th pop, refill attempts start in IDLE.
4. `pop` held high while empty -> `count` stays 0, `dout` unchanged, no underflow.
5. `reset` asserted during WAIT -> all outputs zero immediately; restart follows scenario-1 timing.
6. With `RANDPOOL_NODUP_EN`, `rnd_in` fixed at 0x42 -> one entry accepted, every later sample rejected; `rejects` saturates at 255.
